// File: rtl/stage_mem_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface stage_mem_if #(
  parameter int unsigned WORD_WIDTH = `WORD_WIDTH
) ();
  logic                  dmem_req;
  logic                  dmem_we;
  logic [3:0]            dmem_be;
  logic [WORD_WIDTH-1:0] dmem_addr;
  logic [WORD_WIDTH-1:0] dmem_wdata;
  logic [WORD_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/stage_mem.sv
// MEM pipeline stage: EX/MEM register, data-memory access FSM with timeout,
// load formatting and store lane steering.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module stage_mem #(
  parameter int unsigned WORD_WIDTH     = `WORD_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [WORD_WIDTH-1:0]     rslt_in,
  input  logic [WORD_WIDTH-1:0]     store_d_in,
  input  logic [WORD_WIDTH-1:0]     imm_ext_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                      rd_wen_in,
  input  logic [1:0]                wb_ctl_in,
  input  logic                      mem_rd_in,
  input  logic                      mem_wr_in,
  input  logic [2:0]                funct3_in,
  output logic                      stall_out,
  stage_mem_if.master               dmem,
  output logic [WORD_WIDTH-1:0]     rslt_out,
  output logic [WORD_WIDTH-1:0]     mem_d_out,
  output logic [WORD_WIDTH-1:0]     imm_ext_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
  output logic                      rd_wen_out,
  output logic [1:0]                wb_ctl_out,
  output logic                      mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          wait_cnt;

  logic                      valid_r;
  logic [WORD_WIDTH-1:0]     rslt_r;
  logic [WORD_WIDTH-1:0]     store_d_r;
  logic [WORD_WIDTH-1:0]     imm_ext_r;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
  logic                      rd_wen_r;
  logic [1:0]                wb_ctl_r;
  logic                      mem_rd_r;
  logic                      mem_wr_r;
  logic [2:0]                funct3_r;

  logic [1:0]                byte_off;
  logic                      is_byte;
  logic                      is_half;
  logic                      misaligned;
  logic                      access;
  logic                      pending;
  logic                      timeout_hit;
  logic [WORD_WIDTH-1:0]     rdata_sh;
  logic [WORD_WIDTH-1:0]     load_fmt;
  logic [3:0]                be_lane;
  logic [WORD_WIDTH-1:0]     wdata_lane;

  // EX/MEM register: frozen while the memory access is stalling
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      rslt_r    <= '0;
      store_d_r <= '0;
      imm_ext_r <= '0;
      rd_addr_r <= '0;
      rd_wen_r  <= 1'b0;
      wb_ctl_r  <= 2'b00;
      mem_rd_r  <= 1'b0;
      mem_wr_r  <= 1'b0;
      funct3_r  <= 3'b000;
    end else if (!stall_out) begin
      valid_r   <= valid_in;
      rslt_r    <= rslt_in;
      store_d_r <= store_d_in;
      imm_ext_r <= imm_ext_in;
      rd_addr_r <= rd_addr_in;
      rd_wen_r  <= rd_wen_in;
      wb_ctl_r  <= wb_ctl_in;
      mem_rd_r  <= mem_rd_in;
      mem_wr_r  <= mem_wr_in;
      funct3_r  <= funct3_in;
    end
  end

  // Access size decode: funct3[1:0] = 00 byte, 01 half, anything else word
  assign byte_off    = rslt_r[1:0];
  assign is_byte     = (funct3_r[1:0] == 2'b00);
  assign is_half     = (funct3_r[1:0] == 2'b01);
  assign misaligned  = (is_half && byte_off[0]) ||
                       (!is_byte && !is_half && (byte_off != 2'b00));
  assign access      = valid_r && (mem_rd_r || mem_wr_r);
  assign pending     = access && !misaligned;
  // An ack on the last allowed WAIT cycle beats the abort
  assign timeout_hit = pending && (state == S_WAIT) &&
                       (wait_cnt == TIMEOUT_M1) && !dmem.dmem_ack;

  assign stall_out   = pending && !dmem.dmem_ack && !timeout_hit;
  assign mem_err     = (access && misaligned) || timeout_hit;
  assign rd_wen_out  = valid_r && rd_wen_r && !stall_out && !mem_err;

  // Access FSM and saturating wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending && !dmem.dmem_ack) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!pending || dmem.dmem_ack || timeout_hit) begin
            state <= S_IDLE;
          end else if (wait_cnt != TIMEOUT_M1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load formatting: shift the addressed lane down, then extend
  assign rdata_sh = dmem.dmem_rdata >> {byte_off, 3'b000};

  always_comb begin
    load_fmt = dmem.dmem_rdata;
    case (funct3_r)
      3'b000:  load_fmt = {{(WORD_WIDTH-8){rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_fmt = {{(WORD_WIDTH-8){1'b0}}, rdata_sh[7:0]};
      3'b001:  load_fmt = {{(WORD_WIDTH-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_fmt = {{(WORD_WIDTH-16){1'b0}}, rdata_sh[15:0]};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  // Store steering: byte enables follow the address, data is replicated
  always_comb begin
    be_lane    = 4'b1111;
    wdata_lane = store_d_r;
    if (is_byte) begin
      be_lane    = 4'b0001 << byte_off;
      wdata_lane = WORD_WIDTH'({4{store_d_r[7:0]}});
    end else if (is_half) begin
      be_lane    = 4'b0011 << byte_off;
      wdata_lane = WORD_WIDTH'({2{store_d_r[15:0]}});
    end
  end

  assign dmem.dmem_req   = pending;
  assign dmem.dmem_we    = pending && mem_wr_r;
  assign dmem.dmem_be    = pending ? be_lane : 4'b0000;
  assign dmem.dmem_addr  = {rslt_r[WORD_WIDTH-1:2], 2'b00};
  assign dmem.dmem_wdata = wdata_lane;

  assign mem_d_out   = dmem.dmem_ack ? load_fmt : '0;
  assign rslt_out    = rslt_r;
  assign imm_ext_out = imm_ext_r;
  assign rd_addr_out = rd_addr_r;
  assign wb_ctl_out  = wb_ctl_r;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: expected write-back pushed at issue, popped at retire.
module tb_stage_mem;
  localparam int unsigned WW = 32;
  localparam int unsigned RW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [WW-1:0] rslt_in, store_d_in, imm_ext_in;
  logic [RW-1:0] rd_addr_in;
  logic          rd_wen_in, mem_rd_in, mem_wr_in;
  logic [1:0]    wb_ctl_in;
  logic [2:0]    funct3_in;
  logic          stall_out;
  logic [WW-1:0] rslt_out, mem_d_out, imm_ext_out;
  logic [RW-1:0] rd_addr_out;
  logic          rd_wen_out, mem_err;
  logic [1:0]    wb_ctl_out;

  typedef struct {
    logic [31:0] rslt;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] memd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage_mem_if #(.WORD_WIDTH(WW)) mem_bus ();

  stage_mem #(.WORD_WIDTH(WW), .REG_ADDR_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .rslt_in(rslt_in),
    .store_d_in(store_d_in), .imm_ext_in(imm_ext_in), .rd_addr_in(rd_addr_in),
    .rd_wen_in(rd_wen_in), .wb_ctl_in(wb_ctl_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .funct3_in(funct3_in), .stall_out(stall_out),
    .dmem(mem_bus), .rslt_out(rslt_out), .mem_d_out(mem_d_out),
    .imm_ext_out(imm_ext_out), .rd_addr_out(rd_addr_out), .rd_wen_out(rd_wen_out),
    .wb_ctl_out(wb_ctl_out), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_in = 1'b0; rd_wen_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
  endtask

  // Present one instruction on the EX outputs and record its expected write-back
  task automatic drive_ex(input logic [31:0] rslt, input logic [31:0] sd, input logic [4:0] rd,
                          input logic wen, input logic [1:0] wb, input logic ld, input logic st,
                          input logic [2:0] f3, input logic ewen, input logic [31:0] ememd,
                          input logic eerr);
    exp_t e;
    valid_in = 1'b1; rslt_in = rslt; store_d_in = sd; imm_ext_in = ~rslt;
    rd_addr_in = rd; rd_wen_in = wen; wb_ctl_in = wb; mem_rd_in = ld; mem_wr_in = st;
    funct3_in = f3;
    e = '{rslt, rd, ewen, ememd, eerr};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 1'b1; rslt_in = 32'hDEAD_BEEF; rd_wen_in = 1'b1; mem_rd_in = 1'b1;
    funct3_in = 3'b010; rd_addr_in = 5'd9;
    mem_bus.dmem_ack = 1'b0; mem_bus.dmem_rdata = '0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({mem_bus.dmem_req, stall_out, rd_wen_out, mem_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl got req/stall/wen/err=%b exp=0000",
               {mem_bus.dmem_req, stall_out, rd_wen_out, mem_err});
    end
    n_checks++;
    if (mem_bus.dmem_be !== 4'b0000) begin
      n_fail++; $display("FAIL reset_be got=%b exp=0000", mem_bus.dmem_be);
    end
    n_checks++;
    if ({rslt_out, rd_addr_out} !== 37'd0) begin
      n_fail++; $display("FAIL reset_regs got rslt=%h rd=%0d exp 0", rslt_out, rd_addr_out);
    end
    rst_n = 1'b1;
    bubble();
    tick();
  endtask

  task automatic test_alu();
    exp_t e;
    drive_ex(32'h1234, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 32'h0, 1'b0);
    tick(); bubble();
    @(negedge clk);
    n_checks++;
    if ({mem_bus.dmem_req, stall_out, wb_ctl_out} !== 4'b0000) begin
      n_fail++; $display("FAIL alu_ctl got req/stall/wb=%b exp=0000",
                         {mem_bus.dmem_req, stall_out, wb_ctl_out});
    end
    n_checks++;
    if (imm_ext_out !== 32'hFFFF_EDCB) begin
      n_fail++; $display("FAIL alu_imm got=%h exp=ffffedcb", imm_ext_out);
    end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL alu_retire scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.rd, e.wen, e.memd, e.err}) begin
        n_fail++;
        $display("FAIL alu_retire got rslt=%h rd=%0d wen=%b memd=%h err=%b exp rslt=%h rd=%0d wen=%b memd=%h err=%b",
                 rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.rd, e.wen, e.memd, e.err);
      end
    end
    tick();
  endtask

  task automatic test_load_byte();
    exp_t e;
    drive_ex(32'h103, 32'h0, 5'd7, 1'b1, 2'b10, 1'b1, 1'b0, 3'b000, 1'b1, 32'hFFFF_FF80, 1'b0);
    tick(); bubble();
    mem_bus.dmem_ack = 1'b1; mem_bus.dmem_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    n_checks++;
    if ({mem_bus.dmem_req, mem_bus.dmem_we, stall_out} !== 3'b100) begin
      n_fail++; $display("FAIL lb_ctl got req/we/stall=%b exp=100",
                         {mem_bus.dmem_req, mem_bus.dmem_we, stall_out});
    end
    n_checks++;
    if (mem_bus.dmem_addr !== 32'h100) begin
      n_fail++; $display("FAIL lb_addr got=%h exp=00000100", mem_bus.dmem_addr);
    end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL lb_retire scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.rd, e.wen, e.memd, e.err}) begin
        n_fail++;
        $display("FAIL lb_retire got rslt=%h rd=%0d wen=%b memd=%h err=%b exp rslt=%h rd=%0d wen=%b memd=%h err=%b",
                 rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.rd, e.wen, e.memd, e.err);
      end
    end
    tick();
    mem_bus.dmem_ack = 1'b0;
  endtask

  // Zero-wait loads of every size/sign, one per cycle
  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a [8];
    logic [2:0]  f [8];
    logic [31:0] x [8];
    a = '{32'h101, 32'h100, 32'h102, 32'h100, 32'h104, 32'h108, 32'h102, 32'h100};
    f = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b111, 3'b100, 3'b001};
    x = '{32'hFFFF_FFC3, 32'h0000_00D4, 32'hFFFF_A1B2, 32'h0000_C3D4,
          32'hA1B2_C3D4, 32'hA1B2_C3D4, 32'h0000_00B2, 32'hFFFF_C3D4};
    mem_bus.dmem_ack = 1'b1; mem_bus.dmem_rdata = 32'hA1B2_C3D4;
    drive_ex(a[0], 32'h0, 5'd1, 1'b1, 2'b10, 1'b1, 1'b0, f[0], 1'b1, x[0], 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) drive_ex(a[i+1], 32'h0, 5'(i + 2), 1'b1, 2'b10, 1'b1, 1'b0, f[i+1], 1'b1, x[i+1], 1'b0);
      else bubble();
      @(negedge clk);
      n_checks++;
      if (stall_out !== 1'b0) begin n_fail++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, stall_out); end
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_retire[%0d] scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if ({rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.rd, e.wen, e.memd, e.err}) begin
          n_fail++;
          $display("FAIL b2b_retire[%0d] got rslt=%h rd=%0d wen=%b memd=%h err=%b exp rslt=%h rd=%0d wen=%b memd=%h err=%b",
                   i, rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.rd, e.wen, e.memd, e.err);
        end
      end
    end
    tick();
    mem_bus.dmem_ack = 1'b0;
  endtask

  // Zero-wait stores: byte enables and replicated write data
  task automatic test_store_lanes();
    exp_t e;
    logic [31:0] a [5];
    logic [31:0] d [5];
    logic [2:0]  f [5];
    logic [3:0]  be [5];
    logic [31:0] wd [5];
    a  = '{32'h303, 32'h300, 32'h300, 32'h301, 32'h302};
    d  = '{32'h1234_5678, 32'hCAFE_F00D, 32'h1234_5678, 32'h0000_00AA, 32'h0000_BEEF};
    f  = '{3'b000, 3'b010, 3'b001, 3'b000, 3'b101};
    be = '{4'b1000, 4'b1111, 4'b0011, 4'b0010, 4'b1100};
    wd = '{32'h7878_7878, 32'hCAFE_F00D, 32'h5678_5678, 32'hAAAA_AAAA, 32'hBEEF_BEEF};
    mem_bus.dmem_ack = 1'b1; mem_bus.dmem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      drive_ex(a[i], d[i], 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, f[i], 1'b0, 32'h0, 1'b0);
      tick(); bubble();
      @(negedge clk);
      n_checks++;
      if ({mem_bus.dmem_be, mem_bus.dmem_wdata, mem_bus.dmem_we, stall_out} !== {be[i], wd[i], 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL st_lane[%0d] got be=%b wdata=%h we=%b stall=%b exp be=%b wdata=%h we=1 stall=0",
                 i, mem_bus.dmem_be, mem_bus.dmem_wdata, mem_bus.dmem_we, stall_out, be[i], wd[i]);
      end
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL st_retire[%0d] scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if ({rslt_out, rd_addr_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.rd, e.wen, e.memd, e.err}) begin
          n_fail++;
          $display("FAIL st_retire[%0d] got rslt=%h wen=%b memd=%h err=%b exp rslt=%h wen=%b memd=%h err=%b",
                   i, rslt_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.wen, e.memd, e.err);
        end
      end
      tick();
    end
    mem_bus.dmem_ack = 1'b0;
  endtask

  // SH with a 3-cycle ack delay; the following ALU op must wait upstream
  task automatic test_store_wait();
    exp_t e;
    int stalls = 0;
    bit done = 1'b0;
    mem_bus.dmem_rdata = 32'h0;
    drive_ex(32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0, 1'b0);
    tick();
    drive_ex(32'h55, 32'h0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 20 && !done; k++) begin
      mem_bus.dmem_ack = (k == 3);
      @(negedge clk);
      n_checks++;
      if ({mem_bus.dmem_req, mem_bus.dmem_we, mem_bus.dmem_be, mem_bus.dmem_wdata, mem_bus.dmem_addr, rslt_out} !==
          {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h200, 32'h202}) begin
        n_fail++;
        $display("FAIL sh_wait_bus[%0d] got req=%b we=%b be=%b wdata=%h addr=%h rslt=%h exp 1 1 1100 abcdabcd 00000200 00000202",
                 k, mem_bus.dmem_req, mem_bus.dmem_we, mem_bus.dmem_be, mem_bus.dmem_wdata, mem_bus.dmem_addr, rslt_out);
      end
      if (stall_out) stalls++;
      else begin
        done = 1'b1;
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL sh_retire scoreboard empty"); end
        else begin
          e = sb.pop_front();
          if ({rslt_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.wen, e.memd, e.err}) begin
            n_fail++;
            $display("FAIL sh_retire got rslt=%h wen=%b memd=%h err=%b exp rslt=%h wen=%b memd=%h err=%b",
                     rslt_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.wen, e.memd, e.err);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (!done || stalls != 3) begin
      n_fail++; $display("FAIL sh_stall_count got=%0d done=%b exp=3 done=1", stalls, done);
    end
    mem_bus.dmem_ack = 1'b0;
    bubble();
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL sh_next_retire scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({rslt_out, rd_addr_out, rd_wen_out, mem_err} !== {e.rslt, e.rd, e.wen, e.err}) begin
        n_fail++;
        $display("FAIL sh_next_retire got rslt=%h rd=%0d wen=%b err=%b exp rslt=%h rd=%0d wen=%b err=%b",
                 rslt_out, rd_addr_out, rd_wen_out, mem_err, e.rslt, e.rd, e.wen, e.err);
      end
    end
    tick();
  endtask

  task automatic test_misaligned();
    exp_t e;
    mem_bus.dmem_ack = 1'b0;
    drive_ex(32'h101, 32'h0, 5'd4, 1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0, 1'b1);
    tick();
    drive_ex(32'h201, 32'h1111, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_bus.dmem_req, mem_bus.dmem_be, stall_out} !== 6'b0) begin
        n_fail++; $display("FAIL misal_bus[%0d] got req=%b be=%b stall=%b exp 0 0000 0",
                           i, mem_bus.dmem_req, mem_bus.dmem_be, stall_out);
      end
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL misal_retire[%0d] scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if ({rslt_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.wen, e.memd, e.err}) begin
          n_fail++;
          $display("FAIL misal_retire[%0d] got rslt=%h wen=%b memd=%h err=%b exp rslt=%h wen=%b memd=%h err=%b",
                   i, rslt_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.wen, e.memd, e.err);
        end
      end
      tick();
      bubble();
    end
    @(negedge clk);
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL misal_pulse got err=%b exp=0", mem_err); end
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    int stalls = 0;
    bit done = 1'b0;
    mem_bus.dmem_ack = 1'b0;
    drive_ex(32'h400, 32'h0, 5'd13, 1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0, 1'b1);
    tick(); bubble();
    for (int k = 0; k < 4 * TO && !done; k++) begin
      @(negedge clk);
      if (stall_out) stalls++;
      else begin
        done = 1'b1;
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL to_retire scoreboard empty"); end
        else begin
          e = sb.pop_front();
          if ({rslt_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.wen, e.memd, e.err}) begin
            n_fail++;
            $display("FAIL to_retire got rslt=%h wen=%b memd=%h err=%b exp rslt=%h wen=%b memd=%h err=%b",
                     rslt_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.wen, e.memd, e.err);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (!done || stalls != TO) begin
      n_fail++; $display("FAIL to_stall_count got=%0d done=%b exp=%0d done=1", stalls, done, TO);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_err, mem_bus.dmem_req} !== 2'b00) begin
      n_fail++; $display("FAIL to_after got err/req=%b exp=00", {mem_err, mem_bus.dmem_req});
    end
    tick();
    // FSM back in IDLE: a zero-wait load completes without stalling
    drive_ex(32'h404, 32'h0, 5'd14, 1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 1'b1, 32'h5A5A_1234, 1'b0);
    tick(); bubble();
    mem_bus.dmem_ack = 1'b1; mem_bus.dmem_rdata = 32'h5A5A_1234;
    @(negedge clk);
    n_checks++;
    if (stall_out !== 1'b0) begin n_fail++; $display("FAIL to_idle_stall got=%b exp=0", stall_out); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL to_idle_retire scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({rslt_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.wen, e.memd, e.err}) begin
        n_fail++;
        $display("FAIL to_idle_retire got rslt=%h wen=%b memd=%h err=%b exp rslt=%h wen=%b memd=%h err=%b",
                 rslt_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.wen, e.memd, e.err);
      end
    end
    tick();
    mem_bus.dmem_ack = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    exp_t e;
    int stalls = 0;
    bit done = 1'b0;
    drive_ex(32'h500, 32'h0, 5'd11, 1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 1'b1, 32'h0BAD_F00D, 1'b0);
    tick(); bubble();
    mem_bus.dmem_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4 * TO && !done; k++) begin
      mem_bus.dmem_ack = (k == TO);
      @(negedge clk);
      if (stall_out) stalls++;
      else begin
        done = 1'b1;
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL ackto_retire scoreboard empty"); end
        else begin
          e = sb.pop_front();
          if ({rslt_out, rd_wen_out, mem_d_out, mem_err} !== {e.rslt, e.wen, e.memd, e.err}) begin
            n_fail++;
            $display("FAIL ackto_retire got rslt=%h wen=%b memd=%h err=%b exp rslt=%h wen=%b memd=%h err=%b",
                     rslt_out, rd_wen_out, mem_d_out, mem_err, e.rslt, e.wen, e.memd, e.err);
          end
        end
      end
      tick();
    end
    mem_bus.dmem_ack = 1'b0;
    n_checks++;
    if (!done || stalls != TO) begin
      n_fail++; $display("FAIL ackto_stall_count got=%0d done=%b exp=%0d done=1", stalls, done, TO);
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    mem_bus.dmem_ack = 1'b0;
    drive_ex(32'h600, 32'h0, 5'd12, 1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 1'b1, 32'h0, 1'b0);
    tick(); bubble();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (stall_out !== 1'b1) begin n_fail++; $display("FAIL rstw_pre_stall[%0d] got=%b exp=1", k, stall_out); end
      if (k < 2) tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if ({mem_bus.dmem_req, stall_out, rd_wen_out, mem_err, mem_bus.dmem_be} !== 8'b0) begin
      n_fail++; $display("FAIL rstw_after got req=%b stall=%b wen=%b err=%b be=%b exp all 0",
                         mem_bus.dmem_req, stall_out, rd_wen_out, mem_err, mem_bus.dmem_be);
    end
    tick();
    mem_bus.dmem_ack = 1'b1; mem_bus.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if ({rd_wen_out, mem_bus.dmem_req, stall_out} !== 3'b000) begin
      n_fail++; $display("FAIL rstw_late_ack got wen/req/stall=%b exp=000",
                         {rd_wen_out, mem_bus.dmem_req, stall_out});
    end
    tick();
    mem_bus.dmem_ack = 1'b0;
    drive_ex(32'h77, 32'h0, 5'd15, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 32'h0, 1'b0);
    tick(); bubble();
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL rstw_recover scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({rslt_out, rd_addr_out, rd_wen_out, mem_err} !== {e.rslt, e.rd, e.wen, e.err}) begin
        n_fail++;
        $display("FAIL rstw_recover got rslt=%h rd=%0d wen=%b err=%b exp rslt=%h rd=%0d wen=%b err=%b",
                 rslt_out, rd_addr_out, rd_wen_out, mem_err, e.rslt, e.rd, e.wen, e.err);
      end
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; rslt_in = '0; store_d_in = '0; imm_ext_in = '0; rd_addr_in = '0;
    rd_wen_in = 1'b0; wb_ctl_in = 2'b00; mem_rd_in = 1'b0; mem_wr_in = 1'b0; funct3_in = 3'b000;
    mem_bus.dmem_ack = 1'b0; mem_bus.dmem_rdata = '0;
    test_reset();
    test_alu();
    test_load_byte();
    test_back_to_back();
    test_store_lanes();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_wait();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got=%0d leftover exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default `WORD_WIDTH (32), data/address width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default `REG_ADDR_WIDTH (5), destination register index width.
REQ-003 SHALL have parameter TIMEOUT, default 16, the maximum number of WAIT cycles before an access is aborted.
REQ-004 SHALL use one clock and a synchronous, active-low reset:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- valid_in  in  1  EX output holds a real instruction.
- rslt_in  in  WORD_WIDTH  ALU result, or the effective address for load/store.
- store_d_in  in  WORD_WIDTH  store data (rs2).
- imm_ext_in  in  WORD_WIDTH  extended immediate.
- rd_addr_in  in  REG_ADDR_WIDTH  destination register.
- rd_wen_in  in  1  register write enable.
- wb_ctl_in  in  2  write-back select: 00 rslt, 01 imm, 10 mem.
- mem_rd_in  in  1  load.
- mem_wr_in  in  1  store.
- funct3_in  in  3  access size and sign.
- stall_out  out  1  freeze upstream stages and hold the EX inputs.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store when 1, load when 0.
- dmem_be  out  4  byte enables.
- dmem_addr  out  WORD_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  WORD_WIDTH  lane-aligned store data.
- dmem_rdata  in  WORD_WIDTH  load data, valid when dmem_ack=1.
- dmem_ack  in  1  access complete.
- rslt_out  out  WORD_WIDTH  registered rslt, to WB.
- mem_d_out  out  WORD_WIDTH  formatted load data, to WB.
- imm_ext_out  out  WORD_WIDTH  registered imm_ext, to WB.
- rd_addr_out  out  REG_ADDR_WIDTH  to WB.
- rd_wen_out  out  1  qualified write enable, to WB.
- wb_ctl_out  out  2  to WB.
- mem_err  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-005 The EX/MEM registers (valid, rslt, store_d, imm_ext, rd_addr, rd_wen, wb_ctl, mem_rd, mem_wr, funct3) SHALL load on posedge when stall_out=0 and SHALL hold when stall_out=1.
REQ-006 An access is pending when valid_r=1, mem_rd_r|mem_wr_r=1, the access is aligned, and the FSM is not yet complete.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
REQ-007 The FSM SHALL have two states, IDLE and WAIT.
- IDLE with a pending access: dmem_req=1. If dmem_ack=1, the access completes this cycle. Otherwise the next state is WAIT.
- WAIT: dmem_req=1, with all dmem_* outputs held stable. On dmem_ack=1, the next state is IDLE.
REQ-008 stall_out SHALL equal pending & ~dmem_ack, combinationally. Zero-wait-state memory therefore gives single-cycle throughput.
REQ-009 A saturating wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When the counter reaches TIMEOUT-1 without ack: the access aborts, mem_err=1 for that cycle, stall_out=0, rd_wen_out=0, and the next state is IDLE.
REQ-010 A misaligned access SHALL NOT assert dmem_req.
- It SHALL pulse mem_err=1 and force rd_wen_out=0, with no stall.
REQ-011 rd_wen_out SHALL equal valid_r & rd_wen_r & ~stall_out & ~mem_err. Stall cycles therefore inject bubbles into WB.
REQ-012 Loads SHALL select the byte or halfword lane by addr[1:0] and format by funct3:
- 000 sign-extend byte; 100 zero-extend byte.
- 001 sign-extend half; 101 zero-extend half.
- 010 and all other codes: full word.
REQ-013 Stores SHALL drive dmem_be and dmem_wdata by funct3:
- SB: be=4'b0001<<addr[1:0], data byte replicated to all 4 lanes.
- SH: be=4'b0011<<addr[1:0], data half replicated to both halves.
- SW: be=4'b1111.
- dmem_be=0 when dmem_req=0.
REQ-014 mem_d_out SHALL be the formatted dmem_rdata while dmem_ack=1, and 0 otherwise.
REQ-015 A simultaneous dmem_ack and timeout in the same cycle SHALL complete normally (ack wins), with mem_err=0.

Reset
REQ-016 rst_n=0 at a posedge SHALL take effect at that edge, including mid-WAIT:
- All EX/MEM registers clear to 0, state becomes IDLE, the counter clears.
- Outputs become 0: dmem_req, stall_out, rd_wen_out, mem_err, dmem_be.
- An outstanding ack arriving after reset SHALL be ignored.

Verification
REQ-017 ALU op with rslt_in=0x1234, rd_wen=1, wb_ctl=00 -> next cycle rslt_out=0x1234, rd_wen_out=1, dmem_req=0.
REQ-018 LB at addr 0x103 with dmem_rdata=0x80FFFFFF and ack the same cycle -> mem_d_out=0xFFFFFF80, no stall.
REQ-019 SH at addr 0x202 with store_d=0xABCD and ack after 3 cycles -> be=1100, wdata=0xABCDABCD, stall_out=1 for 3 cycles, then upstream advances.
REQ-020 LW at addr 0x101 -> dmem_req=0, mem_err=1 for 1 cycle, rd_wen_out=0.
REQ-021 LW with no ack -> stall for TIMEOUT cycles, then mem_err pulse and state IDLE.
REQ-022 rst_n=0 during WAIT -> the next cycle has dmem_req=0 and stall_out=0, and a late ack produces no write-back.
